spi_slave_duplex: RTL

Parametrised full-duplex SPI slave and successor to the fixed 8-bit, receive-only, mode-0 slave. It has configurable word width, all four CPOL/CPHA modes, selectable bit order, and pin synchronisers. The block transmits on MISO with a tx valid/ready handshake and presents received words on a valid/ready interface. It reports overrun and framing errors and supports back-to-back words within one chip-select frame. It sits between the board SPI pins and system logic in the sys_clk domain.

---
 rtl/spi_slave_duplex.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/spi_slave_duplex.sv
// Full-duplex SPI slave: parametrised width, CPOL/CPHA mode and bit order, with pin
// synchronisers, tx/rx valid-ready handshakes, and overrun / framing error pulses.
module spi_slave_duplex #(
  parameter int DATA_W      = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int LSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  input  logic              spi_cs_n,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int   CNT_W    = $clog2(DATA_W);
  localparam logic IDLE_LVL = (CPOL != 0);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic [DATA_W-1:0]      rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0]      tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0]      rx_data_q, rx_data_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic                   word_done_q, word_done_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;

  logic sclk_s, mosi_s, cs_s;
  logic lead_edge, trail_edge, sample_edge, shift_edge;
  logic last_bit, tx_load;

  always_comb begin
    sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    cs_s        = cs_sync_q[SYNC_STAGES-1];
    lead_edge   = (sclk_s != sclk_prev_q) && (sclk_s != IDLE_LVL);
    trail_edge  = (sclk_s != sclk_prev_q) && (sclk_s == IDLE_LVL);
    sample_edge = (CPHA == 0) ? lead_edge : trail_edge;
    shift_edge  = (CPHA == 0) ? trail_edge : lead_edge;
    last_bit    = (bit_cnt_q == CNT_W'(DATA_W - 1));
  end

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
    sclk_prev_d = sclk_s;
    state_d     = state_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    rx_data_d   = rx_data_q;
    bit_cnt_d   = bit_cnt_q;
    rx_valid_d  = rx_valid_q;
    word_done_d = 1'b0;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    tx_load     = 1'b0;

    if (rx_ready) rx_valid_d = 1'b0;

    // Word completion is handled a cycle after the final sample so a CS release
    // coinciding with that sample still delivers the word.
    if (word_done_q) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = rx_shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
      if (state_q == SHIFT) tx_load = 1'b1;
    end

    case (state_q)
      WAIT_IDLE: if (cs_s) state_d = IDLE;
      IDLE: begin
        if (!cs_s) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
          tx_load   = 1'b1;
        end
      end
      SHIFT: begin
        if (sample_edge) begin
          rx_shift_d  = (LSB_FIRST != 0) ? {mosi_s, rx_shift_q[DATA_W-1:1]}
                                         : {rx_shift_q[DATA_W-2:0], mosi_s};
          bit_cnt_d   = last_bit ? '0 : bit_cnt_q + 1'b1;
          word_done_d = last_bit;
        end
        // bit_cnt==0 marks the shift-out edge whose bit is already on the wire
        // (first leading edge for CPHA=1, trailing edge after a word for CPHA=0).
        if (shift_edge && (bit_cnt_q != '0)) begin
          tx_shift_d = (LSB_FIRST != 0) ? (tx_shift_q >> 1) : (tx_shift_q << 1);
        end
        if (cs_s) begin
          state_d     = IDLE;
          frame_err_d = (bit_cnt_d != '0);
        end
      end
      default: state_d = WAIT_IDLE;
    endcase

    if (tx_load) tx_shift_d = tx_valid ? tx_data : '0;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= WAIT_IDLE;
      sclk_sync_q <= {SYNC_STAGES{IDLE_LVL}};
      mosi_sync_q <= '0;
      cs_sync_q   <= '0;
      sclk_prev_q <= IDLE_LVL;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      rx_data_q   <= '0;
      bit_cnt_q   <= '0;
      word_done_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      cs_sync_q   <= cs_sync_d;
      sclk_prev_q <= sclk_prev_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      rx_data_q   <= rx_data_d;
      bit_cnt_q   <= bit_cnt_d;
      word_done_q <= word_done_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    busy        = (state_q == SHIFT);
    spi_miso_oe = busy && !cs_s;
    spi_miso    = busy ? ((LSB_FIRST != 0) ? tx_shift_q[0] : tx_shift_q[DATA_W-1]) : 1'b0;
    tx_ready    = tx_load && tx_valid;
    rx_data     = rx_data_q;
    rx_valid    = rx_valid_q;
    frame_err   = frame_err_q;
    overrun     = overrun_q;
  end

endmodule
